sram_1kx1_ctl: RTL and testbench



---
 rtl/sram_1kx1_ctl.sv | 202 ++++++++++++++++++++
 tb/tb_sram_1kx1_ctl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1kx1_ctl.sv
// Sequencer for a bank of WIDTH 1Kx1 asynchronous SRAMs: turns request/ready
// transfers into registered CE_N/WE_N strobes and zero-fills the bank after reset.
module sram_1kx1_ctl #(
    parameter int WIDTH  = 32,
    parameter int SETUP  = 1,
    parameter int PULSE  = 2,
    parameter int ACCESS = 2,
    parameter int CLEAR  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_we,
    input  logic [9:0]       i_req_addr,
    input  logic [WIDTH-1:0] i_req_data,
    output logic             o_rd_valid,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_init_done,
    output logic [9:0]       o_ram_a,
    output logic             o_ram_ce_n,
    output logic             o_ram_we_n,
    output logic [WIDTH-1:0] o_ram_di,
    input  logic [WIDTH-1:0] i_ram_do,
    output logic [3:0]       o_dbg_state
);

    localparam int MAXC = (SETUP > PULSE) ? ((SETUP > ACCESS) ? SETUP : ACCESS)
                                          : ((PULSE > ACCESS) ? PULSE : ACCESS);
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP - 1);
    localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE - 1);
    localparam logic [CW-1:0] ACCESS_LAST = CW'(ACCESS - 1);

    typedef enum logic [3:0] {
        CLR_SETUP = 4'd0,
        CLR_PULSE = 4'd1,
        CLR_HOLD  = 4'd2,
        IDLE      = 4'd3,
        W_SETUP   = 4'd4,
        W_PULSE   = 4'd5,
        W_HOLD    = 4'd6,
        R_ACCESS  = 4'd7,
        R_DONE    = 4'd8
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [9:0]       r_ram_a;
    logic             r_ce_n;
    logic             r_we_n;
    logic [WIDTH-1:0] r_ram_di;
    logic             r_rd_valid;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_init_done;

    state_t           w_state_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [9:0]       w_ram_a_nxt;
    logic             w_ce_n_nxt;
    logic             w_we_n_nxt;
    logic [WIDTH-1:0] w_ram_di_nxt;
    logic             w_rd_valid_nxt;
    logic             w_rd_load;
    logic             w_init_done_nxt;

    // Strobes, address and data all change only at phase boundaries, so the
    // RAM always sees stable address/data around every CE_N/WE_N low window.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + CW'(1);
        w_ram_a_nxt     = r_ram_a;
        w_ce_n_nxt      = r_ce_n;
        w_we_n_nxt      = r_we_n;
        w_ram_di_nxt    = r_ram_di;
        w_rd_valid_nxt  = 1'b0;
        w_rd_load       = 1'b0;
        w_init_done_nxt = r_init_done;
        case (r_state)
            CLR_SETUP: begin
                if (CLEAR == 0) begin
                    w_state_nxt     = IDLE;
                    w_cnt_nxt       = '0;
                    w_init_done_nxt = 1'b1;
                end else if (r_cnt == SETUP_LAST) begin
                    w_state_nxt = CLR_PULSE;
                    w_cnt_nxt   = '0;
                    w_ce_n_nxt  = 1'b0;
                    w_we_n_nxt  = 1'b0;
                end
            end
            CLR_PULSE: begin
                if (r_cnt == PULSE_LAST) begin
                    w_state_nxt = CLR_HOLD;
                    w_cnt_nxt   = '0;
                    w_ce_n_nxt  = 1'b1;
                    w_we_n_nxt  = 1'b1;
                end
            end
            CLR_HOLD: begin
                w_cnt_nxt   = '0;
                w_ram_a_nxt = r_ram_a + 10'd1;
                if (r_ram_a == 10'd1023) begin
                    w_state_nxt     = IDLE;
                    w_init_done_nxt = 1'b1;
                end else begin
                    w_state_nxt = CLR_SETUP;
                end
            end
            IDLE: begin
                w_cnt_nxt = '0;
                if (i_req_valid) begin
                    w_ram_a_nxt = i_req_addr;
                    if (i_req_we) begin
                        w_ram_di_nxt = i_req_data;
                        w_state_nxt  = W_SETUP;
                    end else begin
                        w_ce_n_nxt  = 1'b0;
                        w_state_nxt = R_ACCESS;
                    end
                end
            end
            W_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_state_nxt = W_PULSE;
                    w_cnt_nxt   = '0;
                    w_ce_n_nxt  = 1'b0;
                    w_we_n_nxt  = 1'b0;
                end
            end
            W_PULSE: begin
                if (r_cnt == PULSE_LAST) begin
                    w_state_nxt = W_HOLD;
                    w_cnt_nxt   = '0;
                    w_ce_n_nxt  = 1'b1;
                    w_we_n_nxt  = 1'b1;
                end
            end
            W_HOLD: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
            R_ACCESS: begin
                // Data is captured on the same edge that releases CE_N.
                if (r_cnt == ACCESS_LAST) begin
                    w_state_nxt    = R_DONE;
                    w_cnt_nxt      = '0;
                    w_ce_n_nxt     = 1'b1;
                    w_rd_load      = 1'b1;
                    w_rd_valid_nxt = 1'b1;
                end
            end
            R_DONE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
                w_ce_n_nxt  = 1'b1;
                w_we_n_nxt  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= CLR_SETUP;
            r_cnt       <= '0;
            r_ram_a     <= '0;
            r_ce_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_ram_di    <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ram_a     <= w_ram_a_nxt;
            r_ce_n      <= w_ce_n_nxt;
            r_we_n      <= w_we_n_nxt;
            r_ram_di    <= w_ram_di_nxt;
            r_rd_valid  <= w_rd_valid_nxt;
            r_init_done <= w_init_done_nxt;
            if (w_rd_load) begin
                r_rd_data <= i_ram_do;
            end
        end
    end

    assign o_req_ready = (r_state == IDLE);
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_data   = r_rd_data;
    assign o_init_done = r_init_done;
    assign o_ram_a     = r_ram_a;
    assign o_ram_ce_n  = r_ce_n;
    assign o_ram_we_n  = r_we_n;
    assign o_ram_di    = r_ram_di;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sram_1kx1_ctl.sv
// Bench for sram_1kx1_ctl: RAM models, scoreboard on read results, protocol
// monitor, sweep tracking, and a second instance with non-default timing.
module tb_sram_1kx1_ctl;
  localparam int W  = 32;
  localparam int S  = 1, P  = 2, A  = 2;
  localparam int S2 = 2, P2 = 3, A2 = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a = 1'b1, rst_b = 1'b1;

  // instance A (defaults, CLEAR=1)
  logic          req_valid = 0, req_we = 0;
  logic [9:0]    req_addr = 0;
  logic [W-1:0]  req_data = 0;
  logic          req_ready, rd_valid, init_done, ce_n, we_n;
  logic [W-1:0]  rd_data, ram_di, ram_do;
  logic [9:0]    ram_a;
  logic [3:0]    dbg_a;

  sram_1kx1_ctl #(.WIDTH(W), .SETUP(S), .PULSE(P), .ACCESS(A), .CLEAR(1)) u_dut (
    .clk(clk), .reset(rst_a),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_data(req_data),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_init_done(init_done),
    .o_ram_a(ram_a), .o_ram_ce_n(ce_n), .o_ram_we_n(we_n), .o_ram_di(ram_di),
    .i_ram_do(ram_do), .o_dbg_state(dbg_a)
  );

  // instance B (CLEAR=0, slower timing)
  logic          b_valid = 0, b_we = 0;
  logic [9:0]    b_addr = 0;
  logic [W-1:0]  b_data = 0;
  logic          b_ready, b_rd_valid, b_init_done, b_ce_n, b_we_n;
  logic [W-1:0]  b_rd_data, b_ram_di, b_ram_do;
  logic [9:0]    b_ram_a;
  logic [3:0]    dbg_b;

  sram_1kx1_ctl #(.WIDTH(W), .SETUP(S2), .PULSE(P2), .ACCESS(A2), .CLEAR(0)) u_dut_b (
    .clk(clk), .reset(rst_b),
    .i_req_valid(b_valid), .o_req_ready(b_ready), .i_req_we(b_we),
    .i_req_addr(b_addr), .i_req_data(b_data),
    .o_rd_valid(b_rd_valid), .o_rd_data(b_rd_data), .o_init_done(b_init_done),
    .o_ram_a(b_ram_a), .o_ram_ce_n(b_ce_n), .o_ram_we_n(b_we_n), .o_ram_di(b_ram_di),
    .i_ram_do(b_ram_do), .o_dbg_state(dbg_b)
  );

  // asynchronous RAM models: drive data only while CE_N low and WE_N high
  logic [W-1:0] mem_a [1024];
  logic [W-1:0] mem_b [1024];
  logic fill_req = 1'b1;
  assign ram_do   = (!ce_n && we_n)     ? mem_a[ram_a]   : 32'hA5A5_5A5A;
  assign b_ram_do = (!b_ce_n && b_we_n) ? mem_b[b_ram_a] : 32'h5A5A_A5A5;

  always @(negedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 1024; i++) mem_a[i] = $urandom | 32'h1;
    end else if (!ce_n && !we_n) begin
      mem_a[ram_a] = ram_di;
    end
    if (!b_ce_n && !b_we_n) mem_b[b_ram_a] = b_ram_di;
  end

  // scoreboard state
  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [W-1:0] ref_mem [1024];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: pop the expected read result whenever rd_valid is presented
  always @(negedge clk) begin
    logic [W-1:0] d;
    int c;
    if (!rst_a && rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("rd_valid_unexpected", 32'd1, 32'd0);
      end else begin
        d = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        chk("rd_data", rd_data, d);
        chk("rd_latency_cycle", cyc, c);
      end
    end
  end

  // protocol checker and sweep tracker
  int viol = 0, sweep_pulses = 0, sweep_bad = 0, sw_exp = 0;
  logic prev_ce = 1'b1, prev_we = 1'b1;
  logic [9:0]   prev_a = '0;
  logic [W-1:0] prev_di = '0;
  always @(negedge clk) begin
    if (rst_a) begin
      prev_ce = 1'b1; prev_we = 1'b1;
      sw_exp = 0; sweep_pulses = 0; sweep_bad = 0;
    end else begin
      if (!we_n && ce_n) viol++;
      if (!prev_ce && (ram_a !== prev_a || ram_di !== prev_di)) viol++;
      if (!init_done && prev_we && !we_n) begin
        sweep_pulses++;
        if (ram_a !== sw_exp[9:0] || ram_di !== '0) sweep_bad++;
        sw_exp++;
      end
      prev_ce = ce_n; prev_we = we_n; prev_a = ram_a; prev_di = ram_di;
    end
  end

  // driver: present a request until accepted; acc = edge number of acceptance
  task automatic issue(input logic we, input logic [9:0] addr, input logic [W-1:0] data,
                       input logic hold, output int acc);
    logic r;
    int c;
    acc = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_data = data;
      r = req_ready;
      c = cyc + 1;
      @(posedge clk);
      if (r) begin acc = c; break; end
    end
    if (!hold) #1 req_valid = 1'b0;
    if (acc < 0) begin
      chk("accept_timeout", 32'd1, 32'd0);
    end else if (we) begin
      ref_mem[addr] = data;
    end else begin
      exp_q.push_back(ref_mem[addr]);
      exp_cyc_q.push_back(acc + A);
    end
  endtask

  // release reset from a negedge and check the zero-fill sweep
  task automatic run_sweep();
    int n;
    int nz;
    n = 0;
    rst_a = 1'b0;
    while (!init_done && n < 5000) begin @(negedge clk); n++; end
    chk("sweep_edges", n, 1024 * (S + P + 1));
    chk("sweep_pulses", sweep_pulses, 1024);
    chk("sweep_addr_order", sweep_bad, 0);
    nz = 0;
    for (int i = 0; i < 1024; i++) if (mem_a[i] !== '0) nz++;
    chk("sweep_nonzero_words", nz, 0);
    chk("sweep_ready", req_ready, 1);
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 50) begin @(negedge clk); n++; end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int acc, acc1, acc2, k, lows, lows_ok;
    logic [9:0] ad;
    logic [W-1:0] da;
    logic w;

    // reset state
    repeat (2) @(negedge clk);
    fill_req = 1'b0;
    @(negedge clk);
    chk("rst_ce_n", ce_n, 1);
    chk("rst_we_n", we_n, 1);
    chk("rst_init_done", init_done, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ram_a", ram_a, 0);
    chk("rst_ram_di", ram_di, 0);

    // instance B: no sweep, SETUP=2 PULSE=3 ACCESS=4
    rst_b = 1'b0;
    @(negedge clk);
    chk("b_init_done", b_init_done, 1);
    chk("b_ready", b_ready, 1);
    b_valid = 1'b1; b_we = 1'b1; b_addr = 10'h155; b_data = 32'hCAFE_F00D;
    @(posedge clk);
    #1 b_valid = 1'b0;
    lows = 0;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!b_we_n) lows++;
      if (b_ready) break;
    end
    chk("b_write_accept_to_ready", k, S2 + P2 + 1);
    chk("b_write_pulse_len", lows, P2);
    b_valid = 1'b1; b_we = 1'b0;
    @(posedge clk);
    #1 b_valid = 1'b0;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (b_rd_valid) break;
    end
    chk("b_read_accept_to_valid", k, A2);
    chk("b_read_data", b_rd_data, 32'hCAFE_F00D);

    // sweep from reset
    run_sweep();

    // directed write to top address with strobe timing check
    issue(1'b1, 10'h3FF, 32'hDEAD_BEEF, 1'b0, acc);
    lows_ok = 1;
    for (k = 0; k <= S + P + 1; k++) begin
      @(negedge clk);
      if (we_n !== !(k >= S && k < S + P)) lows_ok = 0;
      if (ce_n !== !(k >= S && k < S + P)) lows_ok = 0;
      if (req_ready !== (k == S + P + 1)) lows_ok = 0;
    end
    chk("write_strobe_sequence", lows_ok, 1);
    issue(1'b0, 10'h3FF, '0, 1'b0, acc);
    lows_ok = 1;
    for (k = 0; k <= A + 1; k++) begin
      @(negedge clk);
      if (ce_n !== (k >= A) || we_n !== 1'b1) lows_ok = 0;
      if (req_ready !== (k == A + 1)) lows_ok = 0;
    end
    chk("read_strobe_sequence", lows_ok, 1);
    issue(1'b0, 10'h000, '0, 1'b0, acc);
    drain();

    // back-to-back writes with req_valid held; IDLE returns S+P+1 edges after
    // an accept and the next accept takes that IDLE cycle
    issue(1'b1, 10'h001, 32'h1, 1'b1, acc1);
    issue(1'b1, 10'h002, 32'h2, 1'b0, acc2);
    chk("b2b_accept_spacing", acc2 - acc1, S + P + 2);
    issue(1'b0, 10'h001, '0, 1'b1, acc);
    issue(1'b0, 10'h002, '0, 1'b0, acc);
    drain();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom_range(0, 1));
      ad = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 15));
      da = $urandom;
      issue(w, ad, da, 1'($urandom_range(0, 1)), acc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
    drain();

    // reset during a write pulse
    issue(1'b1, 10'h0AA, 32'h5555_0001, 1'b0, acc);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!we_n) break;
    end
    chk("found_write_pulse", we_n, 0);
    rst_a = 1'b1;
    @(negedge clk);
    chk("rstw_ce_n", ce_n, 1);
    chk("rstw_we_n", we_n, 1);
    chk("rstw_init_done", init_done, 0);
    chk("rstw_ram_a", ram_a, 0);
    chk("rstw_ready", req_ready, 0);
    run_sweep();

    // reset during a read access
    issue(1'b1, 10'h005, 32'h1234_ABCD, 1'b0, acc);
    issue(1'b0, 10'h005, '0, 1'b0, acc);
    drain();
    chk("rd_data_before_reset", rd_data, 32'h1234_ABCD);
    issue(1'b0, 10'h005, '0, 1'b0, acc);
    @(negedge clk);
    chk("in_read_access", ce_n, 0);
    rst_a = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    chk("rstr_ce_n", ce_n, 1);
    chk("rstr_rd_valid", rd_valid, 0);
    chk("rstr_rd_data", rd_data, 0);
    @(negedge clk);
    rst_a = 1'b0;
    lows = 0;
    repeat (10) begin
      @(negedge clk);
      if (rd_valid) lows++;
    end
    chk("rstr_no_rd_valid", lows, 0);

    chk("protocol_violations", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
